// File: rtl/adc_ram_sched_if.sv
// rtl/adc_ram_sched_if.sv - writer/reader bank handshake and RAM access bundle
// Purpose: groups the ADC-capture (writer) and com-send (reader) handshakes.
// Ports (master = requesters, slave = scheduler):
//   wr_get/wr_rdy/wr_bank/wr_done/wr_stall  writer bank ownership handshake
//   wr_req/wr_ack/wr_off/wr_data            writer word access
//   rd_get/rd_rdy/rd_bank/rd_done           reader bank ownership handshake
//   rd_req/rd_ack/rd_off/rd_valid/rd_data   reader word access and data return
interface adc_ram_sched_if #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 10,
  parameter int BANK_W = 2
);
  logic              wr_get;
  logic              wr_rdy;
  logic [BANK_W-1:0] wr_bank;
  logic              wr_done;
  logic              wr_stall;
  logic              wr_req;
  logic              wr_ack;
  logic [OFF_W-1:0]  wr_off;
  logic [DATA_W-1:0] wr_data;
  logic              rd_get;
  logic              rd_rdy;
  logic [BANK_W-1:0] rd_bank;
  logic              rd_done;
  logic              rd_req;
  logic              rd_ack;
  logic [OFF_W-1:0]  rd_off;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_get, wr_done, wr_req, wr_off, wr_data,
    output rd_get, rd_done, rd_req, rd_off,
    input  wr_rdy, wr_bank, wr_stall, wr_ack,
    input  rd_rdy, rd_bank, rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  wr_get, wr_done, wr_req, wr_off, wr_data,
    input  rd_get, rd_done, rd_req, rd_off,
    output wr_rdy, wr_bank, wr_stall, wr_ack,
    output rd_rdy, rd_bank, rd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/adc_ram_sched.sv
// rtl/adc_ram_sched.sv - bank ring scheduler and round-robin arbiter for the shared sample RAM
// Purpose: hands RAM banks to writer and reader as a ring, tracks occupancy and
// fill level, and grants at most one RAM access per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     writer/reader handshakes and accesses
//   ram_en/ram_we   registered RAM strobes
//   ram_addr        registered {bank, offset}
//   ram_wdata       registered write data
//   ram_rdata       RAM read data, valid one cycle after ram_en
//   full_cnt        full banks waiting for the reader
//   err             sticky: access request without bank ownership
module adc_ram_sched #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 10,
  parameter int BANK_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  adc_ram_sched_if.slave          bus,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [BANK_W+OFF_W-1:0] ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic [BANK_W:0]         full_cnt,
  output logic                    err
);
  localparam int CW = BANK_W + 1;
  localparam logic [BANK_W:0] NBANK = {1'b1, {BANK_W{1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_OWN} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_OWN} r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic [BANK_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BANK_W-1:0]       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [BANK_W:0]         occ_q, occ_d, full_cnt_q, full_cnt_d;
  logic                    rr_q, rr_d;
  logic                    ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [BANK_W+OFF_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]       ram_wdata_q, ram_wdata_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    err_q, err_d;

  logic w_take, w_fill, r_take, r_free;
  logic wr_elig, rd_elig, grant_w, grant_r;

  always_comb begin
    w_state_d = w_state_q;
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    w_take    = 1'b0;
    w_fill    = 1'b0;
    case (w_state_q)
      W_IDLE: if (bus.wr_get) begin
        if (occ_q != NBANK) begin
          w_state_d = W_OWN;
          w_take    = 1'b1;
        end else begin
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: if (occ_q != NBANK) begin
        w_state_d = W_OWN;
        w_take    = 1'b1;
      end
      W_OWN: if (bus.wr_done) begin
        w_state_d = W_IDLE;
        wr_ptr_d  = wr_ptr_q + BANK_W'(1);
        w_fill    = 1'b1;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_take) wr_bank_d = wr_ptr_q;

    r_state_d = r_state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    r_take    = 1'b0;
    r_free    = 1'b0;
    case (r_state_q)
      R_IDLE: if (bus.rd_get) begin
        if (full_cnt_q != '0) begin
          r_state_d = R_OWN;
          r_take    = 1'b1;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: if (full_cnt_q != '0) begin
        r_state_d = R_OWN;
        r_take    = 1'b1;
      end
      R_OWN: if (bus.rd_done) begin
        r_state_d = R_IDLE;
        rd_ptr_d  = rd_ptr_q + BANK_W'(1);
        r_free    = 1'b1;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_take) rd_bank_d = rd_ptr_q;

    // Both FSMs act on pre-edge counts, so a release is only seen by the
    // other side one cycle later; the guards above keep these from wrapping.
    occ_d      = occ_q + CW'(w_take) - CW'(r_free);
    full_cnt_d = full_cnt_q + CW'(w_fill) - CW'(r_take);

    // Round robin: on contention the side that was not granted last wins.
    wr_elig = bus.wr_req && (w_state_q == W_OWN);
    rd_elig = bus.rd_req && (r_state_q == R_OWN);
    grant_w = wr_elig && (!rd_elig || rr_q);
    grant_r = rd_elig && (!wr_elig || !rr_q);
    rr_d    = grant_w ? 1'b0 : (grant_r ? 1'b1 : rr_q);

    ram_en_d    = grant_w || grant_r;
    ram_we_d    = grant_w;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_w) begin
      ram_addr_d  = {wr_bank_q, bus.wr_off};
      ram_wdata_d = bus.wr_data;
    end else if (grant_r) begin
      ram_addr_d = {rd_bank_q, bus.rd_off};
    end

    // RAM returns data the cycle after the registered read strobe.
    rd_valid_d = ram_en_q && !ram_we_q;

    err_d = err_q || (bus.wr_req && (w_state_q != W_OWN))
                  || (bus.rd_req && (r_state_q != R_OWN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      occ_q       <= '0;
      full_cnt_q  <= '0;
      rr_q        <= 1'b1;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      occ_q       <= occ_d;
      full_cnt_q  <= full_cnt_d;
      rr_q        <= rr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.wr_rdy   = (w_state_q == W_OWN);
  assign bus.wr_stall = (w_state_q == W_WAIT);
  assign bus.wr_bank  = wr_bank_q;
  assign bus.wr_ack   = grant_w;
  assign bus.rd_rdy   = (r_state_q == R_OWN);
  assign bus.rd_bank  = rd_bank_q;
  assign bus.rd_ack   = grant_r;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? ram_rdata : '0;

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign full_cnt  = full_cnt_q;
  assign err       = err_q;
endmodule

// File: tb/tb_adc_ram_sched.sv
// tb/tb_adc_ram_sched.sv - self-checking bench for adc_ram_sched
module tb_adc_ram_sched;
  localparam int DATA_W = 16;
  localparam int OFF_W  = 10;
  localparam int BANK_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en, ram_we, err;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [2:0]  full_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_ram_sched_if #(.DATA_W(DATA_W), .OFF_W(OFF_W), .BANK_W(BANK_W)) bus ();

  adc_ram_sched #(.DATA_W(DATA_W), .OFF_W(OFF_W), .BANK_W(BANK_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .full_cnt(full_cnt), .err(err)
  );

  function automatic logic [15:0] init_word(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  // Single-port RAM model: unwritten words read back as init_word(addr).
  logic [15:0] mem [int];
  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : init_word(int'(ram_addr));
    end
  end

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } acc_t;

  acc_t        acc_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] shadow [int];
  logic [1:0]  exp_wr_bank = '0;
  logic [1:0]  exp_rd_bank = '0;

  // Scoreboard push: each grant produces one RAM access; reads also produce data.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.wr_ack === 1'b1) begin
        acc_q.push_back({1'b1, exp_wr_bank, bus.wr_off, bus.wr_data});
        shadow[int'({exp_wr_bank, bus.wr_off})] = bus.wr_data;
      end
      if (bus.rd_ack === 1'b1) begin
        acc_q.push_back({1'b0, exp_rd_bank, bus.rd_off, 16'h0000});
        rd_q.push_back(shadow.exists(int'({exp_rd_bank, bus.rd_off})) ?
                       shadow[int'({exp_rd_bank, bus.rd_off})] :
                       init_word(int'({exp_rd_bank, bus.rd_off})));
      end
    end
  end

  // Scoreboard pop/compare on DUT output.
  always @(negedge clk) begin
    acc_t        e;
    logic [15:0] d;
    if (rst === 1'b0) begin
      if (ram_en === 1'b1) begin
        n_tests++;
        if (acc_q.size() == 0) begin
          n_fail++;
          $display("FAIL ram_access: got ram_en=1 addr=%h, expected no access", ram_addr);
        end else begin
          e = acc_q.pop_front();
          if (ram_we !== e.we || ram_addr !== e.addr || (e.we && ram_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL ram_access: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                     ram_we, ram_addr, ram_wdata, e.we, e.addr, e.wdata);
          end
        end
      end
      if (bus.rd_valid === 1'b1) begin
        n_tests++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_data: got unexpected rd_valid data=%h", bus.rd_data);
        end else begin
          d = rd_q.pop_front();
          if (bus.rd_data !== d) begin
            n_fail++;
            $display("FAIL rd_data: got %h expected %h", bus.rd_data, d);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_get = 0; bus.wr_done = 0; bus.wr_req = 0; bus.wr_off = '0; bus.wr_data = '0;
    bus.rd_get = 0; bus.rd_done = 0; bus.rd_req = 0; bus.rd_off = '0;
    rst = 1;
    step(); step();
    rst = 0;
    @(negedge clk);
    n_tests++;
    if ({bus.wr_rdy, bus.rd_rdy, bus.wr_bank, bus.rd_bank, bus.wr_stall, bus.wr_ack,
         bus.rd_ack, bus.rd_valid, bus.rd_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_handshake: got rdy=%b/%b bank=%h/%b stall=%b ack=%b/%b valid=%b data=%h, expected all 0",
               bus.wr_rdy, bus.rd_rdy, bus.wr_bank, bus.rd_bank, bus.wr_stall,
               bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.rd_data);
    end
    n_tests++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, full_cnt, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_ram: got en=%b we=%b addr=%h wdata=%h full=%0d err=%b, expected all 0",
               ram_en, ram_we, ram_addr, ram_wdata, full_cnt, err);
    end
  endtask

  task automatic test_first_bank();
    step();
    exp_wr_bank = 2'd0;
    bus.wr_get = 1;
    step();
    bus.wr_get = 0;
    @(negedge clk);
    n_tests++;
    if (bus.wr_rdy !== 1'b1 || bus.wr_bank !== 2'd0) begin
      n_fail++;
      $display("FAIL first_get: got wr_rdy=%b wr_bank=%0d, expected 1 and 0", bus.wr_rdy, bus.wr_bank);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      bus.wr_req = 1; bus.wr_off = 10'(i); bus.wr_data = 16'h1000 + 16'(i);
      @(negedge clk);
      n_tests++;
      if (bus.wr_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL solo_write_ack: got %b expected 1 at word %0d", bus.wr_ack, i);
      end
    end
    step();
    bus.wr_req = 0;
    bus.wr_done = 1;
    step();
    bus.wr_done = 0;
    @(negedge clk);
    n_tests++;
    if (bus.wr_rdy !== 1'b0 || full_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL first_done: got wr_rdy=%b full_cnt=%0d, expected 0 and 1", bus.wr_rdy, full_cnt);
    end
  endtask

  task automatic test_fill_stall();
    for (int b = 1; b < 4; b++) begin
      exp_wr_bank = 2'(b);
      step();
      bus.wr_get = 1;
      step();
      bus.wr_get = 0;
      bus.wr_req = 1; bus.wr_off = 10'h005; bus.wr_data = 16'hB000 | 16'(b);
      @(negedge clk);
      n_tests++;
      if (bus.wr_rdy !== 1'b1 || bus.wr_bank !== 2'(b) || bus.wr_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL ring_get: got wr_rdy=%b wr_bank=%0d wr_ack=%b, expected 1, %0d, 1",
                 bus.wr_rdy, bus.wr_bank, bus.wr_ack, b);
      end
      step();
      bus.wr_req = 0;
      bus.wr_done = 1;
      step();
      bus.wr_done = 0;
    end
    @(negedge clk);
    n_tests++;
    if (full_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL full_after_four: got %0d expected 4", full_cnt);
    end
    step();
    bus.wr_get = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      n_tests++;
      if (bus.wr_stall !== 1'b1 || bus.wr_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall: got wr_stall=%b wr_rdy=%b, expected 1 and 0", bus.wr_stall, bus.wr_rdy);
      end
    end
  endtask

  task automatic test_read_release();
    exp_rd_bank = 2'd0;
    step();
    bus.rd_get = 1;
    step();
    bus.rd_get = 0;
    @(negedge clk);
    n_tests++;
    if (bus.rd_rdy !== 1'b1 || bus.rd_bank !== 2'd0 || full_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL rd_get: got rd_rdy=%b rd_bank=%0d full_cnt=%0d, expected 1, 0, 3",
               bus.rd_rdy, bus.rd_bank, full_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      bus.rd_req = 1; bus.rd_off = 10'(i);
      @(negedge clk);
      n_tests++;
      if (bus.rd_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL solo_read_ack: got %b expected 1 at word %0d", bus.rd_ack, i);
      end
    end
    step();
    bus.rd_req = 0;
    step(); step();
    exp_wr_bank = 2'd0;
    bus.rd_done = 1;
    step();
    bus.rd_done = 0;
    @(negedge clk);
    n_tests++;
    if (bus.wr_rdy !== 1'b0 || bus.wr_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL release_plus1: got wr_rdy=%b wr_stall=%b, expected 0 and 1", bus.wr_rdy, bus.wr_stall);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (bus.wr_rdy !== 1'b1 || bus.wr_bank !== 2'd0) begin
      n_fail++;
      $display("FAIL release_plus2: got wr_rdy=%b wr_bank=%0d, expected 1 and 0", bus.wr_rdy, bus.wr_bank);
    end
    bus.wr_get = 0;
  endtask

  task automatic test_read_path();
    exp_rd_bank = 2'd1;
    step();
    bus.rd_get = 1;
    step();
    bus.rd_get = 0;
    bus.rd_req = 1; bus.rd_off = 10'h005;
    @(negedge clk);
    n_tests++;
    if (bus.rd_rdy !== 1'b1 || bus.rd_bank !== 2'd1 || bus.rd_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL read_grant: got rd_rdy=%b rd_bank=%0d rd_ack=%b, expected 1, 1, 1",
               bus.rd_rdy, bus.rd_bank, bus.rd_ack);
    end
    step();
    bus.rd_req = 0;
    @(negedge clk);
    n_tests++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'h405) begin
      n_fail++;
      $display("FAIL read_strobe: got en=%b we=%b addr=%h, expected 1, 0, 405", ram_en, ram_we, ram_addr);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hB001) begin
      n_fail++;
      $display("FAIL read_return: got valid=%b data=%h, expected 1 and b001", bus.rd_valid, bus.rd_data);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (bus.rd_valid !== 1'b0 || ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL read_pulse: got valid=%b ram_en=%b, expected 0 and 0", bus.rd_valid, ram_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] woff, roff;
    logic       wa, ra, exp_w;
    woff = 10'd32;
    roff = 10'd0;
    step();
    for (int i = 0; i < 8; i++) begin
      bus.wr_req = 1; bus.wr_off = woff; bus.wr_data = 16'hC000 + 16'(i);
      bus.rd_req = 1; bus.rd_off = roff;
      @(negedge clk);
      exp_w = (i % 2 == 0);
      n_tests++;
      if (bus.wr_ack !== exp_w || bus.rd_ack !== !exp_w) begin
        n_fail++;
        $display("FAIL alternate: cycle %0d got wr_ack=%b rd_ack=%b, expected %b %b",
                 i, bus.wr_ack, bus.rd_ack, exp_w, !exp_w);
      end
      if (i > 0) begin
        n_tests++;
        if (ram_en !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back_en: cycle %0d got ram_en=%b expected 1", i, ram_en);
        end
      end
      wa = bus.wr_ack;
      ra = bus.rd_ack;
      step();
      if (wa) woff = woff + 10'd1;
      if (ra) roff = roff + 10'd1;
    end
    bus.wr_req = 0;
    bus.rd_req = 0;
    step(); step(); step();
    bus.wr_done = 1;
    bus.rd_done = 1;
    step();
    bus.wr_done = 0;
    bus.rd_done = 0;
    @(negedge clk);
    n_tests++;
    if (full_cnt !== 3'd3 || bus.wr_rdy !== 1'b0 || bus.rd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_release: got full_cnt=%0d wr_rdy=%b rd_rdy=%b, expected 3, 0, 0",
               full_cnt, bus.wr_rdy, bus.rd_rdy);
    end
  endtask

  task automatic test_err();
    step();
    bus.wr_req = 1; bus.wr_off = 10'h007; bus.wr_data = 16'hDEAD;
    @(negedge clk);
    n_tests++;
    if (bus.wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack: got wr_ack=%b expected 0", bus.wr_ack);
    end
    step();
    bus.wr_req = 0;
    @(negedge clk);
    n_tests++;
    if (ram_en !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got ram_en=%b err=%b, expected 0 and 1", ram_en, err);
    end
    step(); step(); step();
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
    n_tests++;
    if (acc_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL drained: got %0d accesses and %0d reads outstanding, expected 0 and 0",
               acc_q.size(), rd_q.size());
    end
    acc_q.delete();
    rd_q.delete();
    step();
    rst = 1;
    #2;
    n_tests++;
    if (err !== 1'b0 || full_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: got err=%b full_cnt=%0d, expected 0 and 0", err, full_cnt);
    end
    step();
    rst = 0;
  endtask

  task automatic test_same_cycle();
    exp_wr_bank = 2'd0;
    step();
    bus.wr_get = 1;
    step();
    bus.wr_get = 0;
    bus.wr_done = 1;
    bus.rd_get = 1;
    step();
    bus.wr_done = 0;
    @(negedge clk);
    n_tests++;
    if (bus.rd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_plus1: got rd_rdy=%b expected 0", bus.rd_rdy);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (bus.rd_rdy !== 1'b1 || bus.rd_bank !== 2'd0 || full_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL same_cycle_plus2: got rd_rdy=%b rd_bank=%0d full_cnt=%0d, expected 1, 0, 0",
               bus.rd_rdy, bus.rd_bank, full_cnt);
    end
    bus.rd_get = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_bank();
    test_fill_stall();
    test_read_release();
    test_read_path();
    test_back_to_back();
    test_err();
    test_same_cycle();
    step(); step();
    n_tests++;
    if (acc_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d accesses and %0d reads outstanding, expected 0 and 0",
               acc_q.size(), rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_ram_sched.md
# adc_ram_sched

Bank scheduler and access arbiter for the shared single-port sample RAM between the ADC capture path (writer) and the com send path (reader). It hands out RAM banks as a ring, tracks bank ownership and fill level, and arbitrates per-cycle RAM accesses with round-robin fairness. It is sequenced by the console: the console starts conversion and send phases, while this block guarantees that writer and reader never share a bank.

## Interface
- DATA_W, 16: sample word width.
- OFF_W, 10: word offset width within a bank (1024 words per bank).
- BANK_W, 2: bank index width (2^BANK_W = 4 banks); ram_addr width = BANK_W+OFF_W.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_get  in  1  writer requests a bank (level, held until wr_rdy).
- wr_rdy  out  1  writer owns wr_bank (level, high in W_OWN).
- wr_bank  out  BANK_W  bank owned by the writer.
- wr_done  in  1  one-cycle pulse: writer bank full, release it to the reader.
- wr_stall  out  1  high in W_WAIT (all banks occupied).
- wr_req / wr_ack  in / out  1  write access request and combinational grant.
- wr_off, wr_data  in  OFF_W, DATA_W  write offset and data, held until wr_ack.
- rd_get, rd_rdy, rd_bank, rd_done  in/out/out/in  1/1/BANK_W/1  reader mirror of the writer bank handshake.
- rd_req / rd_ack  in / out  1  read access request and combinational grant.
- rd_off  in  OFF_W  read offset, held until rd_ack.
- rd_valid, rd_data  out  1, DATA_W  read data return.
- ram_en, ram_we  out  1  registered RAM strobes.
- ram_addr  out  BANK_W+OFF_W  registered {bank, offset}.
- ram_wdata  out  DATA_W  registered write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en.
- full_cnt  out  BANK_W+1  number of FULL banks waiting for the reader.
- err  out  1  sticky: access request made without bank ownership.

## Operation
- State held: wr_ptr, rd_ptr (BANK_W bits, wrap modulo 2^BANK_W), occ (0..4, number of banks that are not FREE), full_cnt, rr (last grant: 0 = write, 1 = read).
- Writer FSM:
  - W_IDLE: on wr_get, go to W_OWN if occ<4, else W_WAIT.
  - W_WAIT: go to W_OWN once occ<4.
  - Entering W_OWN: occ+1 and wr_bank=wr_ptr.
  - W_OWN: on wr_done, go to W_IDLE with wr_ptr+1 and full_cnt+1.
- Reader FSM:
  - R_IDLE: on rd_get, go to R_OWN if full_cnt>0, else R_WAIT.
  - R_WAIT: go to R_OWN once full_cnt>0.
  - Entering R_OWN: full_cnt-1 and rd_bank=rd_ptr.
  - R_OWN: on rd_done, go to R_IDLE with rd_ptr+1 and occ-1.
- Counter updates from both FSMs in the same cycle are summed; occ and full_cnt never wrap.
- Conditions are evaluated on pre-edge counter values:
  - rd_done and a waiting wr_get in the same cycle: the writer is granted one cycle later.
  - wr_done and rd_get in the same cycle with full_cnt=0: the reader is granted one cycle later.
- Arbitration:
  - Eligible requests are wr_req in W_OWN and rd_req in R_OWN.
  - One eligible request: it is granted.
  - Both eligible: the requester not equal to rr is granted; rr updates on every grant; rr resets to 1, so write wins first.
  - Each grant asserts ack combinationally in the same cycle; the transfer happens at that edge.
  - Requester presents the next offset or drops req in the following cycle.
- Ineligible request (req without ownership): never acked; err sets next edge and is cleared only by rst.
- Reset: FSMs IDLE, pointers/occ/full_cnt 0, rr=1, and all outputs 0 (wr_rdy, rd_rdy, wr_bank, rd_bank, wr_stall, acks, rd_valid, rd_data, ram_* , err, full_cnt).
- Reset mid-operation discards all bank contents and ownership; requesters restart with get.

## Timing
- wr_get high at edge N with space: wr_rdy high from N+1.
- Access granted in cycle N: ram_en/we/addr/wdata valid in cycle N+1.
- Read granted in cycle N: rd_valid=1 and rd_data=ram_rdata in cycle N+2; one-cycle pulse.
- Back-to-back grants give one RAM access per cycle; sustained contention alternates W,R,W,R.
- ram_en=0 in any cycle without a grant the cycle before.

## Test plan
- Reset, wr_get=1 -> wr_rdy=1 next cycle, wr_bank=0, occ=1; wr_done -> full_cnt=1, wr_ptr=1.
- Four write bank cycles with no reader, then a fifth wr_get -> wr_stall=1, no wr_rdy.
  - Then rd_get -> rd_bank=0; rd_done at cycle N -> wr_rdy at N+2, wr_bank=0.
- wr_req and rd_req both held continuously while owning -> acks alternate starting with write.
- rd_req with rd_off=0x005 while owning bank 1, acked at N -> ram_addr=0x405 and ram_we=0 at N+1; rd_valid=1 at N+2 with RAM data.
- wr_req=1 in W_IDLE -> wr_ack=0, no ram_en, err=1 next cycle, held until rst.
- wr_done and rd_get in the same cycle with full_cnt=0 -> rd_rdy not asserted next cycle, asserted the cycle after, rd_bank=0.
